serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder that computes the same A+B+CIN result as the ripple-carry chain, one bit per clock through a single `full_adder` instance and a carry flip-flop. It sits directly upstream of a result consumer and downstream of an operand producer, with a valid/ready handshake on both sides. It gives the fault simulator a sequential adder test design, with state, counter and carry register, that is functionally equivalent to the combinational ripple-carry adder.

## Interface
- `WIDTH`, default 4: operand and sum width in bits; legal range 1..32.
- `CLK`  input  1  rising-edge clock.
- `RST`  input  1  asynchronous, active-high reset.
- `IN_VALID`  input  1  producer presents A, B and CIN.
- `IN_READY`  output  1  block can accept operands; high only in IDLE.
- `A`  input  WIDTH  operand A; sampled only on the accept edge.
- `B`  input  WIDTH  operand B; sampled only on the accept edge.
- `CIN`  input  1  carry-in; sampled only on the accept edge.
- `OUT_VALID`  output  1  SUM and COUT hold a complete result; high only in DONE.
- `OUT_READY`  input  1  consumer takes the result.
- `SUM`  output  WIDTH  sum register.
- `COUT`  output  1  final carry-out.
- `BUSY`  output  1  high in SHIFT.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE**
  - IN_READY=1.
  - When IN_VALID=1 on an edge: load A into shift register `ra`, load B into `rb`, load CIN into `carry`, clear bit counter `cnt`, clear SUM, go to SHIFT.
- **SHIFT**, per cycle:
  - `full_adder` inputs: ra[0], rb[0], carry.
  - On the edge: ra and rb shift right by one with zero fill; the full_adder SUM bit enters SUM[WIDTH-1] as SUM shifts right; carry takes the full_adder COUT; cnt increments.
  - When cnt = WIDTH-1 on an edge: that shift completes and the state goes to DONE, with COUT := full_adder COUT.
- **DONE**
  - OUT_VALID=1. SUM and COUT stay stable.
  - When OUT_READY=1 on an edge: go to IDLE.
- **SUM/COUT lifetime:**
  - Both keep the last result through IDLE until the next accept edge.
  - During SHIFT they change every cycle; the consumer must qualify them with OUT_VALID.
- **Arithmetic:** {COUT, SUM} = A + B + CIN, computed modulo 2^(WIDTH+1) with no truncation. Counter width is clog2(WIDTH), minimum 1.
- **Input during busy:** IN_VALID while not in IDLE is ignored; A, B and CIN are not sampled.
- **No overlap:** IN_READY=0 in DONE, so accept and drain never happen on the same edge.
- **WIDTH=1:** SHIFT lasts exactly one cycle.
- **Reset:** RST asynchronously forces state=IDLE and clears ra, rb, carry, cnt, SUM and COUT. It aborts any operation, including mid-SHIFT and in DONE; no partial result is ever flagged valid.

## Timing
- **Reset values:** IN_READY=1; OUT_VALID=0; BUSY=0; SUM=0; COUT=0.
- **Latency:**
  - If operands are accepted on edge k, BUSY=1 from k to k+WIDTH.
  - OUT_VALID=1 from edge k+WIDTH.
  - With OUT_READY held high, the drain happens on edge k+WIDTH+1, and the earliest next accept is edge k+WIDTH+2.
- **Throughput:** one result per WIDTH+2 cycles at best.
- **Output stalls:** OUT_VALID and SUM/COUT hold for any number of OUT_READY-low cycles.
- **Registered outputs:** all outputs are registers or decodes of the state register; there is no combinational path from any input to any output.

## Structure
- Shared package or include contains:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - The default WIDTH.
- Sub-module: one instance of the existing `full_adder`, named `u_fa`, for the per-bit sum and carry.
- Everything else lives in `serial_adder`: FSM, counter, shift registers and the carry flip-flop.

## Test plan
- **Reset idle state:** assert RST mid-cycle with no clock → IN_READY=1, OUT_VALID=0, BUSY=0, SUM=0, COUT=0 immediately.
- **Overflow case:** WIDTH=4, A=4'hF, B=4'h1, CIN=0 accepted on edge k → OUT_VALID from edge k+4, SUM=4'h0, COUT=1.
- **Carry-in case:** A=4'h5, B=4'h3, CIN=1 → SUM=4'h9, COUT=0. Then hold OUT_READY=0 for 3 cycles → SUM/COUT stable, IN_READY=0; a new IN_VALID=1 with A=4'hA is ignored.
- **Reset mid-operation:** pulse RST after two SHIFT edges → IDLE, SUM=0, COUT=0. The next op, A=4'h7, B=4'h7, CIN=1, gives SUM=4'hF, COUT=0.
- **Exhaustive check:** all 512 A/B/CIN combinations at WIDTH=4 with random IN_VALID/OUT_READY gaps. Each {COUT,SUM} must equal A+B+CIN, and each must match the combinational ripple-carry adder output.
- **WIDTH=1 build:** A=1, B=1, CIN=1 → SUM=1, COUT=1, OUT_VALID one edge after accept.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding, default width,
// and the bit-counter sizing helper.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Counter must index bits 0..w-1 and never be narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: sum and carry of three input bits.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, {COUT,SUM} = A+B+CIN, one bit per clock via u_fa.
// Latency: accept on edge k, result valid from edge k+WIDTH, drain on k+WIDTH+1 earliest.
// Backpressure: IN_READY only in IDLE; result held in DONE until OUT_READY.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             BUSY
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last_bit;
    logic             drain;

    full_adder u_fa (
        .a    (ra_q[0]),
        .b    (rb_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_c)
    );

    assign accept   = (state_q == ST_IDLE)  && IN_VALID;
    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    assign drain    = (state_q == ST_DONE)  && OUT_READY;

    assign IN_READY  = (state_q == ST_IDLE);
    assign BUSY      = (state_q == ST_SHIFT);
    assign OUT_VALID = (state_q == ST_DONE);

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at SUM[0].
    always_comb begin
        sum_nxt            = SUM >> 1;
        sum_nxt[WIDTH-1]   = fa_s;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (accept)   state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
            ST_DONE:  if (drain)    state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            SUM     <= '0;
            COUT    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                ra_q    <= A;
                rb_q    <= B;
                carry_q <= CIN;
                cnt_q   <= '0;
                SUM     <= '0;
                COUT    <= 1'b0;
            end else if (state_q == ST_SHIFT) begin
                ra_q    <= ra_q >> 1;
                rb_q    <= rb_q >> 1;
                carry_q <= fa_c;
                cnt_q   <= cnt_q + 1'b1;
                SUM     <= sum_nxt;
                if (last_bit) begin
                    COUT <= fa_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder at WIDTH=4 and WIDTH=1.
module tb_serial_adder;

    logic       CLK = 1'b0;
    logic       clk_en = 1'b0;
    logic       RST = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] sum;
    logic       cout;
    logic       busy;

    logic       w1_in_valid = 1'b0;
    logic       w1_in_ready;
    logic [0:0] w1_a = '0;
    logic [0:0] w1_b = '0;
    logic       w1_cin = 1'b0;
    logic       w1_out_valid;
    logic       w1_out_ready = 1'b0;
    logic [0:0] w1_sum;
    logic       w1_cout;
    logic       w1_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 if (clk_en) CLK = ~CLK;

    serial_adder #(.WIDTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .CIN(cin),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .SUM(sum), .COUT(cout), .BUSY(busy)
    );

    serial_adder #(.WIDTH(1)) dut_w1 (
        .CLK(CLK), .RST(RST),
        .IN_VALID(w1_in_valid), .IN_READY(w1_in_ready),
        .A(w1_a), .B(w1_b), .CIN(w1_cin),
        .OUT_VALID(w1_out_valid), .OUT_READY(w1_out_ready),
        .SUM(w1_sum), .COUT(w1_cout), .BUSY(w1_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ripple(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] r;
        logic       cc;
        cc = c;
        for (int i = 0; i < 4; i++) begin
            r[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (x[i] & cc) | (y[i] & cc);
        end
        r[4] = cc;
        return r;
    endfunction

    // Starts and ends 1 time unit after a rising edge; leaves the DUT in DONE.
    task automatic run4(input logic [3:0] xa, input logic [3:0] xb, input logic xc,
                        input int pre_gap, output int lat);
        int t;
        repeat (pre_gap) begin @(posedge CLK); #1; end
        t = 0;
        while (!in_ready && t < 50) begin @(posedge CLK); #1; t++; end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = xa; b = xb; cin = xc;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge CLK); #1; lat++; end
    endtask

    task automatic drain4(input int hold);
        repeat (hold) begin @(posedge CLK); #1; end
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int gap_in;
        int gap_out;
        logic [4:0] exp5;
        logic [3:0] xa;
        logic [3:0] xb;
        logic       xc;

        // Reset with the clock stopped: outputs must settle immediately.
        #3 RST = 1'b1;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        #3 RST = 1'b0;
        clk_en = 1'b1;
        @(posedge CLK); #1;

        // Overflow: F + 1 + 0 = 1_0000
        in_valid = 1'b1; a = 4'hF; b = 4'h1; cin = 1'b0;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        check("ovf_busy_after_accept", 32'(busy), 32'd1);
        check("ovf_in_ready_busy",     32'(in_ready), 32'd0);
        repeat (3) begin @(posedge CLK); #1; end
        check("ovf_not_valid_early", 32'(out_valid), 32'd0);
        check("ovf_busy_k3",         32'(busy),      32'd1);
        @(posedge CLK); #1;
        check("ovf_valid_k4", 32'(out_valid), 32'd1);
        check("ovf_busy_k4",  32'(busy),      32'd0);
        check("ovf_sum",      32'(sum),       32'h0);
        check("ovf_cout",     32'(cout),      32'd1);
        drain4(0);
        check("ovf_idle_ready", 32'(in_ready),  32'd1);
        check("ovf_idle_valid", 32'(out_valid), 32'd0);
        check("ovf_idle_cout",  32'(cout),      32'd1);

        // Carry-in: 5 + 3 + 1 = 9, then stall and attempt an ignored input.
        run4(4'h5, 4'h3, 1'b1, 0, lat);
        check("cin_latency", 32'(lat),  32'd4);
        check("cin_sum",     32'(sum),  32'h9);
        check("cin_cout",    32'(cout), 32'd0);
        in_valid = 1'b1; a = 4'hA; b = 4'h0; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("stall_sum",       32'(sum),       32'h9);
            check("stall_cout",      32'(cout),      32'd0);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        drain4(0);
        check("stall_sum_after_drain", 32'(sum),      32'h9);
        check("stall_idle",            32'(in_ready), 32'd1);

        // Reset after two SHIFT edges.
        in_valid = 1'b1; a = 4'h3; b = 4'h6; cin = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        RST = 1'b1;
        #1;
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum",       32'(sum),       32'd0);
        check("midrst_cout",      32'(cout),      32'd0);
        #1 RST = 1'b0;
        @(posedge CLK); #1;
        check("midrst_no_valid", 32'(out_valid), 32'd0);
        run4(4'h7, 4'h7, 1'b1, 0, lat);
        check("post_rst_latency", 32'(lat),  32'd4);
        check("post_rst_sum",     32'(sum),  32'hF);
        check("post_rst_cout",    32'(cout), 32'd0);
        drain4(0);

        // All 512 operand combinations with random handshake gaps.
        for (int k = 0; k < 512; k++) begin
            xa = k[3:0];
            xb = k[7:4];
            xc = k[8];
            gap_in  = $urandom_range(0, 2);
            gap_out = $urandom_range(0, 2);
            run4(xa, xb, xc, gap_in, lat);
            exp5 = 5'(xa) + 5'(xb) + 5'(xc);
            check("exh_latency", 32'(lat), 32'd4);
            check("exh_arith",   32'({cout, sum}), 32'(exp5));
            check("exh_ripple",  32'({cout, sum}), 32'(ripple(xa, xb, xc)));
            drain4(gap_out);
        end

        // WIDTH=1: 1 + 1 + 1 = 11
        w1_in_valid = 1'b1; w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1;
        @(posedge CLK); #1;
        w1_in_valid = 1'b0;
        check("w1_busy",      32'(w1_busy),      32'd1);
        check("w1_not_valid", 32'(w1_out_valid), 32'd0);
        @(posedge CLK); #1;
        check("w1_valid", 32'(w1_out_valid), 32'd1);
        check("w1_sum",   32'(w1_sum),       32'd1);
        check("w1_cout",  32'(w1_cout),      32'd1);
        w1_out_ready = 1'b1;
        @(posedge CLK); #1;
        w1_out_ready = 1'b0;
        check("w1_idle", 32'(w1_in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
